// File: rtl/i2s_rx_frame_assembler.sv
// Pairs I2S left/right samples into stereo frames and buffers them in a show-ahead FIFO.
// Ports:
//   mclk, rst_n       - clock (rising edge) and synchronous active-low reset
//   in_data/in_valid/in_lrclk - sample word, level-valid (rising edge = new sample), channel
//   out_left/out_right/out_valid/out_ready - head frame stream toward the FIR datapath
//   level             - number of buffered frames
//   clear_flags       - pulse clearing sync_err and overflow
//   sync_err/overflow - sticky channel-order and dropped-frame flags
module i2s_rx_frame_assembler #(
    parameter int unsigned BIT_DEPTH  = 24,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          mclk,
    input  logic                          rst_n,
    input  logic [BIT_DEPTH-1:0]          in_data,
    input  logic                          in_valid,
    input  logic                          in_lrclk,
    output logic [BIT_DEPTH-1:0]          out_left,
    output logic [BIT_DEPTH-1:0]          out_right,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    input  logic                          clear_flags,
    output logic                          sync_err,
    output logic                          overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic {
        WAIT_LEFT  = 1'b0,
        WAIT_RIGHT = 1'b1
    } state_t;

    state_t                 state, state_nxt;
    logic                   in_valid_q;
    logic                   cap;
    logic [BIT_DEPTH-1:0]   left_hold;
    logic                   hold_load;
    logic                   push_req;
    logic                   sync_set;

    logic [BIT_DEPTH-1:0]   mem_left  [FIFO_DEPTH];
    logic [BIT_DEPTH-1:0]   mem_right [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr, rd_nxt;
    logic [LW-1:0]          level_nxt;
    logic                   full, pop, push_ok, ovf_set;

    // A held-high in_valid produces a single capture on its rising edge.
    assign cap = in_valid & ~in_valid_q;

    // State register.
    always_ff @(posedge mclk) begin
        if (!rst_n) state <= WAIT_LEFT;
        else        state <= state_nxt;
    end

    // Channel-pairing decisions, only on a capture event.
    always_comb begin
        state_nxt = state;
        hold_load = 1'b0;
        push_req  = 1'b0;
        sync_set  = 1'b0;
        if (cap) begin
            case (state)
                WAIT_LEFT: begin
                    if (!in_lrclk) begin
                        hold_load = 1'b1;
                        state_nxt = WAIT_RIGHT;
                    end else begin
                        sync_set = 1'b1;
                    end
                end
                WAIT_RIGHT: begin
                    if (in_lrclk) begin
                        push_req  = 1'b1;
                        state_nxt = WAIT_LEFT;
                    end else begin
                        // Newest left sample replaces the orphaned one.
                        sync_set  = 1'b1;
                        hold_load = 1'b1;
                    end
                end
                default: state_nxt = WAIT_LEFT;
            endcase
        end
    end

    // FIFO control: a pop frees the slot a same-cycle push needs when full.
    always_comb begin
        full      = (level == LW'(FIFO_DEPTH));
        pop       = out_valid & out_ready;
        push_ok   = push_req & (~full | pop);
        ovf_set   = push_req & full & ~pop;
        rd_nxt    = pop ? rd_ptr + AW'(1) : rd_ptr;
        level_nxt = level + LW'(push_ok) - LW'(pop);
    end

    // Frame storage; contents need no reset since outputs are separately registered.
    always_ff @(posedge mclk) begin
        if (push_ok) begin
            mem_left[wr_ptr]  <= left_hold;
            mem_right[wr_ptr] <= in_data;
        end
    end

    // Pointers, level, capture history and held left sample.
    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            in_valid_q <= 1'b0;
            left_hold  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            out_valid  <= 1'b0;
        end else begin
            in_valid_q <= in_valid;
            if (hold_load) left_hold <= in_data;
            if (push_ok)   wr_ptr    <= wr_ptr + AW'(1);
            rd_ptr    <= rd_nxt;
            level     <= level_nxt;
            out_valid <= (level_nxt != '0);
        end
    end

    // Registered copy of the next head frame; holds when the FIFO goes empty.
    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            out_left  <= '0;
            out_right <= '0;
        end else if (level_nxt != '0) begin
            if (push_ok && (rd_nxt == wr_ptr) && (level_nxt == LW'(1))) begin
                out_left  <= left_hold;
                out_right <= in_data;
            end else begin
                out_left  <= mem_left[rd_nxt];
                out_right <= mem_right[rd_nxt];
            end
        end
    end

    // Sticky flags; a same-cycle set beats clear_flags.
    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            sync_err <= 1'b0;
            overflow <= 1'b0;
        end else begin
            sync_err <= sync_set | (sync_err & ~clear_flags);
            overflow <= ovf_set  | (overflow & ~clear_flags);
        end
    end

endmodule

// File: tb/tb_i2s_rx_frame_assembler.sv
// Scenario-driven bench for i2s_rx_frame_assembler with an expected-frame queue.
module tb_i2s_rx_frame_assembler;

    localparam int unsigned BD = 24;
    localparam int unsigned FD = 4;

    logic          mclk = 1'b0;
    logic          rst_n;
    logic [BD-1:0] in_data;
    logic          in_valid;
    logic          in_lrclk;
    logic [BD-1:0] out_left, out_right;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    level;
    logic          clear_flags;
    logic          sync_err, overflow;

    int vectors = 0;
    int miscompares = 0;
    logic [2*BD-1:0] exp_q [$];

    i2s_rx_frame_assembler #(.BIT_DEPTH(BD), .FIFO_DEPTH(FD)) dut (
        .mclk(mclk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_lrclk(in_lrclk), .out_left(out_left), .out_right(out_right),
        .out_valid(out_valid), .out_ready(out_ready), .level(level),
        .clear_flags(clear_flags), .sync_err(sync_err), .overflow(overflow)
    );

    always #5 mclk = ~mclk;

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic send_sample(input logic lr, input logic [BD-1:0] d);
        in_data  = d;
        in_lrclk = lr;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic send_frame(input logic [BD-1:0] l, input logic [BD-1:0] r);
        send_sample(1'b0, l);
        send_sample(1'b1, r);
    endtask

    task automatic pulse_clear();
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
    endtask

    // Pops expected frames as the DUT presents them; bounded by a cycle budget.
    task automatic drain();
        logic [2*BD-1:0] e;
        int budget = 60;
        out_ready = 1'b1;
        while (budget > 0) begin
            if (out_valid) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL drain_extra: got frame %h_%h required none", out_left, out_right);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_left, out_right} !== e) begin
                        miscompares++;
                        $display("FAIL drain_frame: got %h_%h required %h_%h",
                                 out_left, out_right, e[2*BD-1:BD], e[BD-1:0]);
                    end
                end
            end else if (exp_q.size() == 0) begin
                break;
            end
            tick();
            budget--;
        end
        out_ready = 1'b0;
        if (budget == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d frames left required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        vectors++;
        if ({level, out_valid, sync_err, overflow} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_status: got lvl=%0d v=%b se=%b ov=%b required 0", level, out_valid, sync_err, overflow);
        end
        vectors++;
        if ({out_left, out_right} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got %h_%h required 0", out_left, out_right);
        end
    endtask

    task automatic test_normal_pair();
        logic [2*BD-1:0] e;
        out_ready = 1'b1;
        send_sample(1'b0, 24'h123456);
        exp_q.push_back({24'h123456, 24'hABCDEF});
        in_data  = 24'hABCDEF;
        in_lrclk = 1'b1;
        in_valid = 1'b1;
        tick();
        vectors++;
        e = exp_q.pop_front();
        if (!(out_valid === 1'b1 && {out_left, out_right} === e)) begin
            miscompares++;
            $display("FAIL pair_latency: got v=%b %h_%h required v=1 %h_%h",
                     out_valid, out_left, out_right, e[2*BD-1:BD], e[BD-1:0]);
        end
        for (int i = 0; i < 9; i++) tick();
        in_valid = 1'b0;
        tick();
        vectors++;
        if ({out_valid, level, sync_err} !== 5'b0) begin
            miscompares++;
            $display("FAIL pair_single_capture: got v=%b lvl=%0d se=%b required 0", out_valid, level, sync_err);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_order_error();
        send_sample(1'b1, 24'h000001);
        vectors++;
        if (sync_err !== 1'b1) begin
            miscompares++;
            $display("FAIL order_sync_err: got %b required 1", sync_err);
        end
        send_sample(1'b0, 24'h000002);
        send_sample(1'b0, 24'h000003);
        send_sample(1'b1, 24'h000004);
        exp_q.push_back({24'h000003, 24'h000004});
        vectors++;
        if (level !== 3'd1) begin
            miscompares++;
            $display("FAIL order_level: got %0d required 1", level);
        end
        drain();
        pulse_clear();
        vectors++;
        if (sync_err !== 1'b0) begin
            miscompares++;
            $display("FAIL order_clear: got %b required 0", sync_err);
        end
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send_frame(BD'(24'h100000 + i), BD'(24'h200000 + i));
            if (i <= 4) exp_q.push_back({BD'(24'h100000 + i), BD'(24'h200000 + i)});
        end
        vectors++;
        if ({level, overflow} !== {3'd4, 1'b1}) begin
            miscompares++;
            $display("FAIL overflow_state: got lvl=%0d ov=%b required lvl=4 ov=1", level, overflow);
        end
        drain();
        pulse_clear();
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL overflow_clear: got %b required 0", overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic [2*BD-1:0] e;
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            send_frame(BD'(24'h300000 + i), BD'(24'h400000 + i));
            exp_q.push_back({BD'(24'h300000 + i), BD'(24'h400000 + i)});
        end
        send_sample(1'b0, 24'h300005);
        exp_q.push_back({24'h300005, 24'h400005});
        in_data   = 24'h400005;
        in_lrclk  = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        vectors++;
        e = exp_q.pop_front();
        if (!(out_valid === 1'b1 && {out_left, out_right} === e)) begin
            miscompares++;
            $display("FAIL fullpp_head: got v=%b %h_%h required v=1 %h_%h",
                     out_valid, out_left, out_right, e[2*BD-1:BD], e[BD-1:0]);
        end
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        vectors++;
        if ({level, overflow} !== {3'd4, 1'b0}) begin
            miscompares++;
            $display("FAIL fullpp_level: got lvl=%0d ov=%b required lvl=4 ov=0", level, overflow);
        end
        tick();
        drain();
    endtask

    task automatic test_midframe_reset();
        send_sample(1'b0, 24'h0000AA);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        send_sample(1'b1, 24'h0000BB);
        vectors++;
        if ({sync_err, level, out_valid} !== {1'b1, 3'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL midreset: got se=%b lvl=%0d v=%b required se=1 lvl=0 v=0", sync_err, level, out_valid);
        end
        pulse_clear();
    endtask

    initial begin
        rst_n = 1'b0; in_data = '0; in_valid = 1'b0; in_lrclk = 1'b0;
        out_ready = 1'b0; clear_flags = 1'b0;
        #1;
        test_reset();
        test_normal_pair();
        test_order_error();
        test_overflow();
        test_full_push_pop();
        test_midframe_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i2s_rx_frame_assembler.md
Name: i2s_rx_frame_assembler

Overview:
Sits directly downstream of the I2S codec interface receive path, in the mclk domain. It captures each completed per-channel sample, pairs a left sample with the following right sample into one stereo frame, and buffers frames in a small show-ahead FIFO. Frames leave on a valid/ready stream toward the FIR datapath. Channel-order errors and FIFO overflow are reported through sticky flags.

Parameters:
BIT_DEPTH, 24, width of each channel sample and of the in_data port.
FIFO_DEPTH, 4, number of stereo frames buffered; must be a power of two and at least 2.

Ports:
mclk  input  1  system/codec master clock; all logic is on its rising edge.
rst_n  input  1  synchronous reset, active-low.
in_data  input  BIT_DEPTH  received sample word from the I2S receiver; stable while in_valid is high.
in_valid  input  1  level signal from the receiver; its rising edge marks a new completed sample.
in_lrclk  input  1  channel of the sample being captured: 0 = left, 1 = right.
out_left  output  BIT_DEPTH  left sample of the FIFO head frame.
out_right  output  BIT_DEPTH  right sample of the FIFO head frame.
out_valid  output  1  FIFO holds at least one frame.
out_ready  input  1  consumer accepts the head frame when out_valid is also high.
level  output  $clog2(FIFO_DEPTH)+1  number of frames currently buffered.
clear_flags  input  1  single-cycle pulse that clears both sticky flags.
sync_err  output  1  sticky flag: channel order violated.
overflow  output  1  sticky flag: a frame was dropped because the FIFO was full.

Behaviour:
- Reset (rst_n=0 at a mclk edge):
  - FSM enters WAIT_LEFT; in_valid_q=0; FIFO is emptied (level=0, out_valid=0).
  - out_left, out_right, sync_err and overflow all read 0; left_hold=0.
  - A reset mid-frame discards any held left sample and all buffered frames.
- Capture event: cap = in_valid & ~in_valid_q, where in_valid_q is a 1-cycle register of in_valid.
  - A held-high in_valid yields exactly one event.
  - in_valid is sampled directly; bclk is derived from mclk, so no synchroniser is used.
- FSM, evaluated only when cap=1:
  - WAIT_LEFT, in_lrclk=0: left_hold <= in_data; go to WAIT_RIGHT.
  - WAIT_LEFT, in_lrclk=1: discard the sample; set sync_err; stay in WAIT_LEFT.
  - WAIT_RIGHT, in_lrclk=1: push {left_hold, in_data} into the FIFO; go to WAIT_LEFT.
  - WAIT_RIGHT, in_lrclk=0: set sync_err; left_hold <= in_data (newest left sample wins); stay in WAIT_RIGHT.
- FIFO:
  - Show-ahead: out_left/out_right always present the head frame; out_valid = (level!=0).
  - Pop occurs when out_valid & out_ready.
  - Push latency: a push at edge N gives out_valid=1 from cycle N+1 if the FIFO was empty. There is no combinational path from in_* to out_*.
  - Push when full without a pop in the same cycle: the frame is dropped, overflow is set, and FIFO contents are unchanged.
  - Push and pop in the same cycle when full: the push is accepted and level stays at FIFO_DEPTH.
  - Push and pop in the same cycle when empty: no pop occurs (out_valid=0); the push is accepted and level becomes 1.
  - Pointers wrap modulo FIFO_DEPTH; level ranges from 0 to FIFO_DEPTH.
- When out_valid=0, out_left/out_right hold the last head value. Consumers must ignore them.
- Flags:
  - Both flags are sticky until clear_flags or reset.
  - If clear_flags and a new set condition occur in the same cycle, the set wins (flag reads 1).
- The block applies no sign extension or arithmetic; samples pass through bit-exact.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles, release -> level=0, out_valid=0, sync_err=0, overflow=0, out_left=out_right=0.
- Normal pair: capture left 0x123456 then right 0xABCDEF with out_ready=1 -> exactly one frame with out_left=0x123456, out_right=0xABCDEF; out_valid high 1 cycle after the right-sample capture edge; in_valid held high for 10 cycles yields only one capture.
- Order error: capture right 0x000001 first, then left 0x000002, left 0x000003, right 0x000004 -> sync_err=1 after the first capture; the single output frame is (0x000003, 0x000004); clear_flags pulse -> sync_err=0.
- Overflow: out_ready=0; push 5 frames with FIFO_DEPTH=4 -> level=4, overflow=1; draining gives frames 1-4 in order and frame 5 is lost.
- Full push+pop: FIFO full, out_ready=1 on the same cycle as a push -> level stays 4, overflow=0, order preserved.
- Mid-frame reset: left captured, rst_n=0 for 1 cycle, then a right capture -> sync_err=1, no frame pushed, level=0.
